// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
// Multi-digit BCD up/down counter with a step prescaler, synchronous
// parallel load (with per-digit clamp to 9) and a terminal-count strobe.
// Optional build macro:
//   CNT_SATURATE_EN - a step taken at the limit for the current direction
//                     leaves q unchanged instead of wrapping around.
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1
) (
    input  logic                  clki,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  direction,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  step,
    output logic                  tc
);

    localparam int QW = 4 * DIGITS;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PS_ONE  = PW'(1);

    // Value with every digit set to nine (down-count reset value).
    function automatic logic [QW-1:0] all_nines();
        logic [QW-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Clamp every nibble above nine to nine so q always holds valid BCD.
    function automatic logic [QW-1:0] clamp_bcd(input logic [QW-1:0] v);
        logic [QW-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    logic [PW-1:0] presc_r;
    logic [QW-1:0] q_r;
    logic          step_r;
    logic          tc_r;

    logic          step_take_s;
    logic [QW-1:0] q_step_s;
    logic [QW-1:0] q_count_s;
    logic          at_limit_s;

    // A count step is taken when enabled at the end of a prescaler period and no load overrides it.
    always_comb begin
        step_take_s = 1'b0;
        if (enable && !load && (presc_r == PS_LAST)) begin
            step_take_s = 1'b1;
        end else begin
            step_take_s = 1'b0;
        end
    end

    // Single-cycle carry/borrow chain across all digits; the chain surviving past the MSD means q is at the limit.
    always_comb begin
        logic       chain_v;
        logic [3:0] digit_v;
        logic [3:0] next_v;
        logic       lim_v;
        chain_v    = 1'b1;
        q_step_s   = q_r;
        at_limit_s = 1'b0;
        digit_v    = 4'd0;
        next_v     = 4'd0;
        lim_v      = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_v = q_r[4*i +: 4];
            if (direction) begin
                lim_v  = (digit_v == 4'd0);
                next_v = lim_v ? 4'd9 : (digit_v - 4'd1);
            end else begin
                lim_v  = (digit_v == 4'd9);
                next_v = lim_v ? 4'd0 : (digit_v + 4'd1);
            end
            if (chain_v) begin
                q_step_s[4*i +: 4] = next_v;
            end else begin
                q_step_s[4*i +: 4] = digit_v;
            end
            chain_v = chain_v & lim_v;
        end
        at_limit_s = chain_v;
    end

    // Select wrap-around or saturating result for a step taken at the limit.
    always_comb begin
        q_count_s = q_step_s;
`ifdef CNT_SATURATE_EN
        if (at_limit_s) begin
            q_count_s = q_r;
        end else begin
            q_count_s = q_step_s;
        end
`else
        q_count_s = q_step_s;
`endif
    end

    // Prescaler: restarts on load, advances while enabled, wraps after a step.
    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            presc_r <= '0;
        end else if (load) begin
            presc_r <= '0;
        end else if (enable) begin
            if (presc_r == PS_LAST) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PS_ONE;
            end
        end else begin
            presc_r <= presc_r;
        end
    end

    // Count register and one-cycle step/tc strobes; reset value follows direction.
    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            q_r    <= direction ? all_nines() : '0;
            step_r <= 1'b0;
            tc_r   <= 1'b0;
        end else if (load) begin
            q_r    <= clamp_bcd(load_val);
            step_r <= 1'b0;
            tc_r   <= 1'b0;
        end else if (step_take_s) begin
            q_r    <= q_count_s;
            step_r <= 1'b1;
            tc_r   <= at_limit_s;
        end else begin
            q_r    <= q_r;
            step_r <= 1'b0;
            tc_r   <= 1'b0;
        end
    end

    assign q    = q_r;
    assign step = step_r;
    assign tc   = tc_r;

endmodule
